// File: rtl/binary_to_bcd.sv
// binary_to_bcd: combinational double-dabble conversion with a registered output stage
module binary_to_bcd #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   out,
    output logic                  out_valid
);
    logic [4*DIGITS-1:0] bcd;
    always_comb begin
        bcd = '0;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++)
                bcd[4*d +: 4] = (bcd[4*d +: 4] >= 4'd5) ? bcd[4*d +: 4] + 4'd3 : bcd[4*d +: 4];
            bcd = {bcd[4*DIGITS-2:0], in[i]};
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out <= bcd;
        end
    end
endmodule

// File: tb/tb_binary_to_bcd.sv
// tb_binary_to_bcd: scoreboard-driven bench for binary_to_bcd
module tb_binary_to_bcd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in = '0;
    logic        in_valid = 1'b0;
    logic [11:0] out;
    logic        out_valid;
    logic [11:0] q[$];
    logic [11:0] exp;
    int errors = 0;
    int checks = 0;

    binary_to_bcd #(.IN_WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model(input int v);
        return 12'((v / 100) << 8 | ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    task automatic drive(input int v, input logic vld, input logic r);
        @(negedge clk);
        in = 8'(v);
        in_valid = vld;
        rst = r;
        if (vld && !r) q.push_back(model(v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] pop();
        return q.size() != 0 ? q.pop_front() : 12'hxxx;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(99, 1'b1, 1'b1);
            tick();
            checks++;
            if (out !== 12'h000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%h valid=%b expected out=000 valid=0", k, out, out_valid);
            end
        end
        drive(99, 1'b1, 1'b0);
        tick();
        exp = pop();
        checks++;
        if (out !== exp || out_valid !== 1'b1 || exp !== 12'h099) begin
            errors++;
            $display("FAIL reset_release: out=%h valid=%b expected out=099 valid=1", out, out_valid);
        end
    endtask

    task automatic test_directed();
        int vals[11] = '{1, 112, 251, 0, 156, 45, 255, 100, 124, 235, 50};
        foreach (vals[k]) begin
            drive(vals[k], 1'b1, 1'b0);
            tick();
            exp = pop();
            checks++;
            if (out !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed in=%0d: out=%h valid=%b expected out=%h valid=1", vals[k], out, out_valid, exp);
            end
        end
    endtask

    task automatic test_hold();
        drive(235, 1'b1, 1'b0);
        tick();
        exp = pop();
        checks++;
        if (out !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_capture: out=%h valid=%b expected out=%h valid=1", out, out_valid, exp);
        end
        for (int k = 0; k < 3; k++) begin
            drive(7, 1'b0, 1'b0);
            tick();
            checks++;
            if (out !== 12'h235 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: out=%h valid=%b expected out=235 valid=0", k, out, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int vals[3] = '{9, 10, 99};
        foreach (vals[k]) begin
            drive(vals[k], 1'b1, 1'b0);
            tick();
            exp = pop();
            checks++;
            if (out !== exp || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream in=%0d: out=%h valid=%b expected out=%h valid=1", vals[k], out, out_valid, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(200, 1'b1, 1'b0);
        tick();
        exp = pop();
        checks++;
        if (out !== exp || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: out=%h valid=%b expected out=%h valid=1", out, out_valid, exp);
        end
        drive(77, 1'b1, 1'b1);
        tick();
        checks++;
        if (out !== 12'h000 || out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset: out=%h valid=%b pending=%0d expected out=000 valid=0 pending=0", out, out_valid, q.size());
        end
        drive(0, 1'b0, 1'b0);
        tick();
        checks++;
        if (out !== 12'h000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: out=%h valid=%b expected out=000 valid=0", out, out_valid);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 256; v++) begin
            drive(v, 1'b1, 1'b0);
            tick();
            exp = pop();
            checks++;
            if (out !== exp || out_valid !== 1'b1 || out[11:8] > 4'd2 || out[7:4] > 4'd9 || out[3:0] > 4'd9
                || int'(out[11:8]) * 100 + int'(out[7:4]) * 10 + int'(out[3:0]) != v) begin
                errors++;
                $display("FAIL sweep in=%0d: out=%h valid=%b expected out=%h valid=1", v, out, out_valid, exp);
            end
        end
        drive(0, 1'b0, 1'b0);
        tick();
        checks++;
        if (out !== 12'h255 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_end: out=%h valid=%b expected out=255 valid=0", out, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
- Converts an unsigned binary value into packed BCD digits: hundreds, tens, ones.
- Uses the shift-and-add-3 (double-dabble) algorithm, evaluated combinationally within one cycle, with a registered output stage.
- Used in display/debug paths that need a decimal readout of byte-wide values.
- Default configuration: 8-bit input, 3-digit (12-bit) output.

Parameters:
- IN_WIDTH, 8, width of the unsigned binary input.
- DIGITS, 3, number of BCD digits in the output. Must satisfy 10^DIGITS > 2^IN_WIDTH - 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in  input  IN_WIDTH  unsigned binary value to convert.
- in_valid  input  1  qualifies `in` for capture on this rising edge.
- out  output  4*DIGITS  packed BCD: out[11:8] = hundreds, out[7:4] = tens, out[3:0] = ones (default sizes).
- out_valid  output  1  high for exactly one cycle per accepted conversion.

Behaviour:
- Reset: on a rising edge with rst=1, out <= 0 and out_valid <= 0. Reset overrides in_valid.
  - Reset asserted mid-stream discards that cycle's input; no output is produced for it.
- Conversion:
  - Combinational double-dabble over IN_WIDTH iterations.
  - Before each left shift, any BCD digit ≥ 5 gets +3.
  - Result is exact decimal: out = hundreds*256 + tens*16 + ones, with each nibble in 0..9.
- Latency and handshake:
  - Rising edge with rst=0 and in_valid=1: out <= BCD(in), out_valid <= 1.
  - Rising edge with rst=0 and in_valid=0: out holds its last value, out_valid <= 0.
  - No backpressure. A new input may be accepted every cycle; throughput is 1 per cycle.
  - Back-to-back valid inputs produce back-to-back outputs in order, with out_valid staying high.
- Arithmetic and width rules:
  - Input is always treated as unsigned.
  - For IN_WIDTH=8 the hundreds digit is never above 2.
  - Unused upper digit bits are always 0.
  - Output nibbles never take values 10..15.
- Boundaries:
  - in=0 gives out=12'h000.
  - in=255 gives out=12'h255.
  - Exact multiples of 10 and 100 give zero lower digits (e.g. 100 gives 12'h100).
  - out is stable between valid captures.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in=8'd99, in_valid=1 → out=12'h000, out_valid=0. Release rst → next valid capture yields 12'h099.
- Directed values, one per cycle with in_valid=1, each checked one cycle later:
  - 1 → 12'h001 (0000_0000_0001)
  - 112 → 12'h112 (0001_0001_0010)
  - 251 → 12'h251 (0010_0101_0001)
  - 0 → 12'h000
  - 156 → 12'h156
  - 45 → 12'h045
  - 255 → 12'h255
  - 100 → 12'h100
  - 124 → 12'h124
  - 235 → 12'h235
  - 50 → 12'h050
- Hold behaviour: capture 235, then drive in=7 with in_valid=0 for 3 cycles → out stays 12'h235, out_valid=0 on those cycles.
- Streaming: valid inputs 9, 10, 99 on consecutive cycles → outputs 12'h009, 12'h010, 12'h099 on consecutive cycles with out_valid continuously 1.
- Reset mid-stream: valid 200, then rst=1 together with valid 77 → out=12'h000 and out_valid=0 after that edge; 77 is never output.
- Exhaustive sweep 0..255 → every nibble ≤ 9 and hundreds*100 + tens*10 + ones equals the input.
